// File: rtl/adder_tree_sched.sv
// adder_tree_sched: round-robin scheduler that shares one pipelined adder tree
// among NUM_REQ requesters and accumulates the tree outputs into one result per job.
module adder_tree_sched #(
    parameter  int NUM_REQ  = 4,
    parameter  int NUM_IN   = 8,
    parameter  int DW_DATA  = 8,
    parameter  int TREE_LAT = 3,
    parameter  int DW_ACC   = 16,
    parameter  int DW_CNT   = 8,
    localparam int IDW      = $clog2(NUM_REQ),
    localparam int BW       = NUM_IN * DW_DATA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [NUM_REQ*BW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [BW-1:0]         tree_in,
    input  logic [DW_DATA-1:0]    tree_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DW_ACC-1:0]     res_data,
    output logic [IDW-1:0]        res_id,
    output logic [DW_CNT-1:0]     res_beats,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    // Handshakes: a beat (req_*) or result (res_*) transfers at a rising clk edge
    // where valid and ready are both high; valid never waits on ready.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [DW_CNT-1:0] CNT_MAX = {DW_CNT{1'b1}};

    state_t              state, state_n;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      grant;
    logic [IDW-1:0]      pick;
    logic [IDW-1:0]      idx;
    logic                found;
    logic [DW_ACC-1:0]   acc;
    logic [DW_CNT-1:0]   cnt;
    logic [TREE_LAT-1:0] vpipe;
    logic [TREE_LAT-1:0] lastpipe;
    logic                fire;
    logic                fire_last;
    logic                retire;
    logic                retire_last;
    logic                res_fire;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = rr_ptr + IDW'(i);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign fire        = (state == ISSUE) && req_valid[grant];
    assign fire_last   = fire && req_last[grant];
    assign retire      = vpipe[TREE_LAT-1];
    assign retire_last = retire && lastpipe[TREE_LAT-1];
    assign res_fire    = (state == OUT) && res_ready;

    always_comb begin
        req_ready = '0;
        tree_in   = '0;
        if (state == ISSUE) begin
            req_ready[grant] = 1'b1;
        end
        if (fire) begin
            tree_in = req_data[int'(grant)*BW +: BW];
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (|req_valid) state_n = ISSUE;
            ISSUE:   if (fire_last) state_n = DRAIN;
            DRAIN:   state_n = DRAIN;
            OUT:     if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // The last beat leaving the tree closes the job from either active state.
        if ((state == ISSUE || state == DRAIN) && retire_last) begin
            state_n = OUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant    <= '0;
            acc      <= '0;
            cnt      <= '0;
            vpipe    <= '0;
            lastpipe <= '0;
        end else begin
            state    <= state_n;
            vpipe    <= (vpipe << 1) | TREE_LAT'(fire);
            lastpipe <= (lastpipe << 1) | TREE_LAT'(fire_last);
            if (state == IDLE && (|req_valid)) begin
                grant <= pick;
            end
            if (res_fire) begin
                acc    <= '0;
                cnt    <= '0;
                rr_ptr <= grant + IDW'(1);
            end else begin
                if (retire) begin
                    acc <= acc + DW_ACC'(tree_out);
                end
                if (fire && cnt != CNT_MAX) begin
                    cnt <= cnt + DW_CNT'(1);
                end
            end
        end
    end

    // Accumulator, counter and grant are frozen in OUT, so they serve as the result registers.
    assign res_valid = (state == OUT);
    assign res_data  = acc;
    assign res_beats = cnt;
    assign res_id    = grant;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_adder_tree_sched.sv
// Bench for adder_tree_sched: a behavioural adder tree, per-requester beat streams,
// and a job-level model that predicts each result and the round-robin order.
`timescale 1ns/1ps
module tb_adder_tree_sched;

    localparam int NUM_REQ  = 4;
    localparam int NUM_IN   = 8;
    localparam int DW_DATA  = 8;
    localparam int TREE_LAT = 3;
    localparam int DW_ACC   = 16;
    localparam int DW_CNT   = 4;
    localparam int IDW      = 2;
    localparam int BW       = NUM_IN * DW_DATA;
    localparam int W        = IDW + DW_CNT + DW_ACC;
    localparam int MAXB     = 64;
    localparam int MAXJ     = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_last;
    logic [NUM_REQ*BW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [BW-1:0]         tree_in;
    logic [DW_DATA-1:0]    tree_out;
    logic                  res_valid;
    logic                  res_ready;
    logic [DW_ACC-1:0]     res_data;
    logic [IDW-1:0]        res_id;
    logic [DW_CNT-1:0]     res_beats;
    logic                  busy;
    logic [1:0]            dbg_state;

    adder_tree_sched #(
        .NUM_REQ(NUM_REQ), .NUM_IN(NUM_IN), .DW_DATA(DW_DATA),
        .TREE_LAT(TREE_LAT), .DW_ACC(DW_ACC), .DW_CNT(DW_CNT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .tree_in(tree_in), .tree_out(tree_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .res_beats(res_beats), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural adder tree ----------------
    function automatic logic [DW_DATA-1:0] elem_sum(input logic [BW-1:0] v);
        logic [DW_DATA-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_IN; k++) s = s + v[k*DW_DATA +: DW_DATA];
        return s;
    endfunction

    logic [DW_DATA-1:0] tpipe [TREE_LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TREE_LAT; k++) tpipe[k] <= '0;
        end else begin
            tpipe[0] <= elem_sum(tree_in);
            for (int k = 1; k < TREE_LAT; k++) tpipe[k] <= tpipe[k-1];
        end
    end
    assign tree_out = tpipe[TREE_LAT-1];

    // ---------------- stream state, scoreboard ----------------
    logic [BW-1:0] beat_mem [NUM_REQ][MAXB];
    bit            last_mem [NUM_REQ][MAXB];
    bit            gap_mem  [NUM_REQ][MAXB];
    int            nb [NUM_REQ];
    int            pos [NUM_REQ];
    bit            gap_done [NUM_REQ];

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  obs_q[$];
    int            fire_cyc_q[$];
    int            cyc;
    int            last_fire_cyc;
    int            rv_rise_cyc;
    int            stall_left;
    int            stall_seen;
    int            stab_viol;
    int            ready_viol;
    bit            prev_rv;
    logic [W-1:0]  prev_res;
    int            model_ptr;
    int            checks;
    int            passed;

    function automatic logic [W-1:0] mk(input int id, input int beats, input int data);
        return {IDW'(id), DW_CNT'(beats), DW_ACC'(data)};
    endfunction

    function automatic logic [BW-1:0] rep(input logic [DW_DATA-1:0] e);
        return {NUM_IN{e}};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_streams();
        for (int r = 0; r < NUM_REQ; r++) begin
            nb[r] = 0;
            pos[r] = 0;
            gap_done[r] = 1'b0;
        end
        exp_q.delete();
        obs_q.delete();
        fire_cyc_q.delete();
        last_fire_cyc = -1;
        rv_rise_cyc = -1;
        stall_left = 0;
        stall_seen = 0;
        stab_viol = 0;
        ready_viol = 0;
        prev_rv = 1'b0;
    endtask

    task automatic add_beat(input int r, input logic [BW-1:0] d, input bit l, input bit g);
        beat_mem[r][nb[r]] = d;
        last_mem[r][nb[r]] = l;
        gap_mem[r][nb[r]] = g;
        nb[r]++;
    endtask

    task automatic present();
        for (int r = 0; r < NUM_REQ; r++) begin
            req_valid[r] = 1'b0;
            req_last[r] = 1'b0;
            req_data[r*BW +: BW] = '0;
            if (pos[r] < nb[r]) begin
                if (gap_mem[r][pos[r]] && !gap_done[r]) begin
                    gap_done[r] = 1'b1;
                end else begin
                    req_valid[r] = 1'b1;
                    req_last[r] = last_mem[r][pos[r]];
                    req_data[r*BW +: BW] = beat_mem[r][pos[r]];
                end
            end
        end
        res_ready = (stall_left == 0);
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] fired;
        @(negedge clk);
        cyc++;
        fired = req_valid & req_ready;
        if (res_valid && (|req_ready)) ready_viol++;
        if (prev_rv && res_valid && ({res_id, res_beats, res_data} !== prev_res)) stab_viol++;
        if (res_valid && rv_rise_cyc < 0) rv_rise_cyc = cyc;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (fired[r]) begin
                fire_cyc_q.push_back(cyc);
                if (req_last[r] && last_fire_cyc < 0) last_fire_cyc = cyc;
            end
        end
        if (res_valid && res_ready) obs_q.push_back({res_id, res_beats, res_data});
        if (res_valid && !res_ready) begin
            stall_seen++;
            if (stall_left > 0) stall_left--;
        end
        prev_rv = res_valid && !res_ready;
        prev_res = {res_id, res_beats, res_data};
        @(posedge clk);
        #1;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (fired[r]) begin
                pos[r]++;
                gap_done[r] = 1'b0;
            end
        end
        present();
    endtask

    task automatic run_until(input int n, input int budget);
        int k;
        k = 0;
        while (obs_q.size() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (obs_q.size() < n) $display("FAIL result_timeout: got %0d results, need %0d", obs_q.size(), n);
        else passed++;
    endtask

    task automatic do_reset(input int cycles);
        clear_streams();
        present();
        rst = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // ---------------- reference model ----------------
    // Splits every stream into jobs, sums each job's wrapped tree sums, then
    // serves jobs round-robin from the model pointer.
    task automatic build_expect();
        logic [DW_ACC-1:0] js [NUM_REQ][MAXJ];
        int                jn [NUM_REQ][MAXJ];
        int                nj [NUM_REQ];
        int                nxt [NUM_REQ];
        logic [DW_ACC-1:0] sum;
        int                n, total, r, sat_max;
        bit                got;
        total = 0;
        sat_max = (1 << DW_CNT) - 1;
        for (int q = 0; q < NUM_REQ; q++) begin
            nj[q] = 0;
            nxt[q] = 0;
            sum = '0;
            n = 0;
            for (int k = 0; k < nb[q]; k++) begin
                sum = sum + DW_ACC'(elem_sum(beat_mem[q][k]));
                n++;
                if (last_mem[q][k]) begin
                    js[q][nj[q]] = sum;
                    jn[q][nj[q]] = n;
                    nj[q]++;
                    total++;
                    sum = '0;
                    n = 0;
                end
            end
        end
        while (total > 0) begin
            got = 1'b0;
            r = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!got && nxt[(model_ptr + i) % NUM_REQ] < nj[(model_ptr + i) % NUM_REQ]) begin
                    got = 1'b1;
                    r = (model_ptr + i) % NUM_REQ;
                end
            end
            exp_q.push_back(mk(r, (jn[r][nxt[r]] > sat_max) ? sat_max : jn[r][nxt[r]],
                               int'(js[r][nxt[r]])));
            nxt[r]++;
            model_ptr = (r + 1) % NUM_REQ;
            total--;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++; if (req_ready !== '0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else passed++;
        checks++; if (tree_in !== '0) $display("FAIL reset_tree_in: got %h want 0", tree_in); else passed++;
        checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else passed++;
        checks++; if (res_data !== '0) $display("FAIL reset_res_data: got %0d want 0", res_data); else passed++;
        checks++; if (res_id !== '0) $display("FAIL reset_res_id: got %0d want 0", res_id); else passed++;
        checks++; if (res_beats !== '0) $display("FAIL reset_res_beats: got %0d want 0", res_beats); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [W-1:0] got;
        clear_streams();
        for (int k = 0; k < 3; k++) add_beat(0, rep(8'h01), k == 2, 1'b0);
        build_expect();
        present();
        run_until(1, 100);
        got = (obs_q.size() > 0) ? obs_q[0] : '0;
        checks++; if (got !== exp_q[0]) $display("FAIL single_model: got %h want %h", got, exp_q[0]); else passed++;
        checks++; if (got !== mk(0, 3, 24)) $display("FAIL single_value: got %h want %h", got, mk(0, 3, 24)); else passed++;
        // Sampling at negedge puts the first observed res_valid one sample after edge L+TREE_LAT.
        checks++;
        if (rv_rise_cyc - last_fire_cyc != TREE_LAT + 1)
            $display("FAIL single_latency: got %0d want %0d", rv_rise_cyc - last_fire_cyc, TREE_LAT + 1);
        else passed++;
        for (int k = 0; k < 8; k++) step();
        checks++; if (obs_q.size() != 1) $display("FAIL single_count: got %0d want 1", obs_q.size()); else passed++;
    endtask

    task automatic test_tree_wrap();
        logic [W-1:0] got;
        clear_streams();
        add_beat(1, rep(8'h21), 1'b1, 1'b0);
        build_expect();
        present();
        run_until(1, 100);
        got = (obs_q.size() > 0) ? obs_q[0] : '0;
        checks++; if (got !== exp_q[0]) $display("FAIL wrap_model: got %h want %h", got, exp_q[0]); else passed++;
        checks++; if (got[DW_ACC-1:0] !== 16'd8) $display("FAIL wrap_value: got %0d want 8", got[DW_ACC-1:0]); else passed++;
    endtask

    task automatic test_round_robin();
        logic [W-1:0] got;
        logic [W-1:0] want [5];
        do_reset(1);
        for (int r = 0; r < NUM_REQ; r++) add_beat(r, rep(DW_DATA'(r + 1)), 1'b1, 1'b0);
        add_beat(0, rep(8'h01), 1'b1, 1'b0);
        want[0] = mk(0, 1, 8);
        want[1] = mk(1, 1, 16);
        want[2] = mk(2, 1, 24);
        want[3] = mk(3, 1, 32);
        want[4] = mk(0, 1, 8);
        build_expect();
        present();
        run_until(5, 200);
        for (int i = 0; i < 5; i++) begin
            got = (obs_q.size() > i) ? obs_q[i] : '0;
            checks++; if (got !== exp_q[i]) $display("FAIL rr_model_%0d: got %h want %h", i, got, exp_q[i]); else passed++;
            checks++; if (got !== want[i]) $display("FAIL rr_order_%0d: got %h want %h", i, got, want[i]); else passed++;
        end
        // One-beat jobs with res_ready high: next fire lands TREE_LAT+3 edges after the previous.
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (fire_cyc_q.size() < 5 || fire_cyc_q[i] - fire_cyc_q[i-1] != TREE_LAT + 3)
                $display("FAIL rr_spacing_%0d: got %0d want %0d", i,
                         (fire_cyc_q.size() < 5) ? -1 : fire_cyc_q[i] - fire_cyc_q[i-1], TREE_LAT + 3);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] got;
        clear_streams();
        for (int k = 0; k < 4; k++) add_beat(2, rep(8'h02), k == 3, k != 0);
        add_beat(3, rep(8'h03), 1'b1, 1'b0);
        build_expect();
        stall_left = 5;
        present();
        run_until(2, 300);
        for (int i = 0; i < 2; i++) begin
            got = (obs_q.size() > i) ? obs_q[i] : '0;
            checks++; if (got !== exp_q[i]) $display("FAIL bp_model_%0d: got %h want %h", i, got, exp_q[i]); else passed++;
        end
        got = (obs_q.size() > 0) ? obs_q[0] : '0;
        checks++; if (got !== mk(2, 4, 64)) $display("FAIL bp_value: got %h want %h", got, mk(2, 4, 64)); else passed++;
        checks++; if (stall_seen != 5) $display("FAIL bp_stall_len: got %0d want 5", stall_seen); else passed++;
        checks++; if (stab_viol != 0) $display("FAIL bp_stable: got %0d changes want 0", stab_viol); else passed++;
        checks++; if (ready_viol != 0) $display("FAIL bp_ready_in_out: got %0d want 0", ready_viol); else passed++;
        checks++;
        if (fire_cyc_q.size() < 4 || fire_cyc_q[3] - fire_cyc_q[0] != 6)
            $display("FAIL bp_bubbles: got %0d want 6",
                     (fire_cyc_q.size() < 4) ? -1 : fire_cyc_q[3] - fire_cyc_q[0]);
        else passed++;
    endtask

    task automatic test_saturation();
        logic [W-1:0] got;
        clear_streams();
        for (int k = 0; k < 20; k++) add_beat(3, rep(8'h01), k == 19, 1'b0);
        build_expect();
        present();
        run_until(1, 200);
        got = (obs_q.size() > 0) ? obs_q[0] : '0;
        checks++; if (got !== exp_q[0]) $display("FAIL sat_model: got %h want %h", got, exp_q[0]); else passed++;
        checks++; if (got !== mk(3, 15, 160)) $display("FAIL sat_value: got %h want %h", got, mk(3, 15, 160)); else passed++;
        checks++;
        if (fire_cyc_q.size() != 20 || fire_cyc_q[19] - fire_cyc_q[0] != 19)
            $display("FAIL sat_back_to_back: got %0d fires want 20 on consecutive edges", fire_cyc_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] got;
        int k;
        clear_streams();
        for (int b = 0; b < 3; b++) add_beat(0, rep(8'h01), b == 2, 1'b0);
        present();
        k = 0;
        while (pos[0] < 2 && k < 50) begin
            step();
            k++;
        end
        checks++; if (pos[0] != 2) $display("FAIL midrst_setup: got %0d beats want 2", pos[0]); else passed++;
        do_reset(1);
        @(negedge clk);
        checks++; if (req_ready !== '0) $display("FAIL midrst_req_ready: got %b want 0", req_ready); else passed++;
        checks++; if (tree_in !== '0) $display("FAIL midrst_tree_in: got %h want 0", tree_in); else passed++;
        checks++; if (res_valid !== 1'b0) $display("FAIL midrst_res_valid: got %b want 0", res_valid); else passed++;
        checks++; if (res_data !== '0) $display("FAIL midrst_res_data: got %0d want 0", res_data); else passed++;
        checks++; if (res_beats !== '0) $display("FAIL midrst_res_beats: got %0d want 0", res_beats); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
        checks++; if (dbg_state !== 2'd0) $display("FAIL midrst_state: got %0d want 0", dbg_state); else passed++;
        @(posedge clk);
        #1;
        clear_streams();
        add_beat(0, rep(8'h01), 1'b1, 1'b0);
        build_expect();
        present();
        run_until(1, 100);
        got = (obs_q.size() > 0) ? obs_q[0] : '0;
        checks++; if (got !== mk(0, 1, 8)) $display("FAIL midrst_fresh: got %h want %h", got, mk(0, 1, 8)); else passed++;
        checks++; if (got !== exp_q[0]) $display("FAIL midrst_model: got %h want %h", got, exp_q[0]); else passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] got;
        int jobs, beats;
        for (int round = 0; round < 4; round++) begin
            clear_streams();
            for (int r = 0; r < NUM_REQ; r++) begin
                jobs = (r == round) ? $urandom_range(1, 2) : $urandom_range(0, 2);
                for (int j = 0; j < jobs; j++) begin
                    beats = $urandom_range(1, 5);
                    for (int b = 0; b < beats; b++)
                        add_beat(r, {$urandom, $urandom}, b == beats - 1, (b != 0) && ($urandom_range(0, 3) == 0));
                end
            end
            build_expect();
            stall_left = $urandom_range(0, 3);
            present();
            run_until(exp_q.size(), 1500);
            for (int k = 0; k < 8; k++) step();
            for (int i = 0; i < exp_q.size(); i++) begin
                got = (obs_q.size() > i) ? obs_q[i] : '0;
                checks++;
                if (got !== exp_q[i]) $display("FAIL rand_r%0d_%0d: got %h want %h", round, i, got, exp_q[i]);
                else passed++;
            end
            checks++;
            if (obs_q.size() != exp_q.size())
                $display("FAIL rand_count_r%0d: got %0d want %0d", round, obs_q.size(), exp_q.size());
            else passed++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        passed = 0;
        cyc = 0;
        model_ptr = 0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        res_ready = 1'b1;
        do_reset(2);
        test_reset();
        test_single();
        test_tree_wrap();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
